// File: rtl/fetch_line_cache_pkg.sv
// Shared types for the fetch line cache: entry payload, fill FSM states, default sizing.
// Imported by the interface and the cache block.
package fetch_line_cache_pkg;

  localparam int LINE_ENTRIES_DEFAULT = 4;
  localparam int ADDR_W               = 32;
  localparam int TAG_W                = 28;
  localparam int LINE_W               = 128;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } LineCacheEntry_;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2
  } LineFetchState_;

  // Line tag of a 16-byte-aligned window address; the low nibble is the byte offset.
  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:4];
  endfunction

endpackage

// File: rtl/fetch_line_cache_if.sv
// Front-end lookup and instruction-memory fill signals of the fetch line cache.
// slave = the cache itself, master = prefetch queue plus instruction memory.
interface fetch_line_cache_if;
  import fetch_line_cache_pkg::*;

  logic              redirect;
  logic              invalidate;
  logic [ADDR_W-1:0] alignedAddress;
  logic [LINE_W-1:0] instructionFetchData;
  logic              instructionFetchDataValid;
  logic              memRequestValid;
  logic [ADDR_W-1:0] memRequestAddress;
  logic              memRequestReady;
  logic              memResponseValid;
  logic [LINE_W-1:0] memResponseData;

  modport slave (
    input  redirect, invalidate, alignedAddress,
    input  memRequestReady, memResponseValid, memResponseData,
    output instructionFetchData, instructionFetchDataValid,
    output memRequestValid, memRequestAddress
  );

  modport master (
    output redirect, invalidate, alignedAddress,
    output memRequestReady, memResponseValid, memResponseData,
    input  instructionFetchData, instructionFetchDataValid,
    input  memRequestValid, memRequestAddress
  );

endinterface

// File: rtl/fetch_line_cache.sv
// Fully associative instruction line cache: hit data one cycle after lookup, single outstanding fill.
// Request held until memRequestReady; misses during a fill are dropped and re-presented upstream.
module fetch_line_cache
  import fetch_line_cache_pkg::*;
#(
  parameter int LINE_ENTRIES = LINE_ENTRIES_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  fetch_line_cache_if.slave   bus
);

  localparam int IDX_W = $clog2(LINE_ENTRIES);

  LineCacheEntry_    entries_q [LINE_ENTRIES];
  LineCacheEntry_    entries_d [LINE_ENTRIES];
  LineFetchState_    state_q, state_d;
  logic [IDX_W-1:0]  victim_q, victim_d;
  logic              squash_q, squash_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic              out_vld_q, out_vld_d;
  logic [LINE_W-1:0] out_data_q, out_data_d;

  logic [TAG_W-1:0]  lookup_tag;
  logic              hit;
  logic [LINE_W-1:0] hit_data;
  logic              fill;
  logic              bypass;

  assign lookup_tag = line_tag(bus.alignedAddress);

  // Tags are unique (fills only follow misses), so OR-ing the matching lines is a clean mux.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < LINE_ENTRIES; i++) begin
      if (entries_q[i].valid && (entries_q[i].tag == lookup_tag)) begin
        hit      = 1'b1;
        hit_data = hit_data | entries_q[i].data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    squash_d   = squash_q;
    miss_tag_d = miss_tag_q;
    entries_d  = entries_q;
    fill       = 1'b0;
    bypass     = 1'b0;

    if (bus.invalidate) begin
      for (int i = 0; i < LINE_ENTRIES; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (!hit && !bus.redirect && !bus.invalidate) begin
          miss_tag_d = lookup_tag;
          state_d    = REQUEST;
        end
      end
      REQUEST: begin
        if (bus.invalidate) begin
          squash_d = 1'b1;
        end
        if (bus.memRequestReady) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.memResponseValid) begin
          // A same-cycle invalidate must win over the returning line.
          fill     = !squash_q && !bus.invalidate;
          bypass   = fill && (lookup_tag == miss_tag_q) && !bus.redirect;
          squash_d = 1'b0;
          state_d  = IDLE;
        end else if (bus.invalidate) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fill) begin
      entries_d[victim_q].valid = 1'b1;
      entries_d[victim_q].tag   = miss_tag_q;
      entries_d[victim_q].data  = bus.memResponseData;
      victim_d                  = victim_q + IDX_W'(1);
    end

    out_vld_d  = (hit || bypass) && !bus.redirect && !bus.invalidate;
    out_data_d = bypass ? bus.memResponseData : hit_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINE_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      state_q    <= IDLE;
      victim_q   <= '0;
      squash_q   <= 1'b0;
      miss_tag_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      entries_q  <= entries_d;
      state_q    <= state_d;
      victim_q   <= victim_d;
      squash_q   <= squash_d;
      miss_tag_q <= miss_tag_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.instructionFetchData      = out_data_q;
  assign bus.instructionFetchDataValid = out_vld_q;
  assign bus.memRequestValid           = (state_q == REQUEST);
  assign bus.memRequestAddress         = {miss_tag_q, 4'b0000};

endmodule
